// File: rtl/conv_pool_seq.sv
// conv_pool_seq: binary-activation conv accumulate + max-pool with internal tap sequencer.
//
// One pooled output per START. Each accepted activation beat adds the current tap's
// weight into every lane whose activation bit is set (saturating). Lanes are then
// shifted, clamped to OW bits and max-reduced sequentially; the winner and its lane
// index are presented on a valid/ready output port.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   START      begin a new output (sampled only in IDLE)
//   RELU_EN    clamp pooled result at 0 (latched at START)
//   W_IN       TAPS signed weights, tap t at [t*WW +: WW], stable from START to OUT handshake
//   A_IN       activation bits for the current tap, bit i = lane i
//   A_VALID    A_IN valid
//   A_READY    block accepts a beat (ACC state)
//   CMP        signed pooled result
//   MAX_IDX    winning lane
//   OUT_VALID  CMP/MAX_IDX valid
//   OUT_READY  consumer accepts output
//   BUSY       high in any state except IDLE
module conv_pool_seq #(
  parameter int unsigned NCH   = 9,
  parameter int unsigned TAPS  = 9,
  parameter int unsigned WW    = 8,
  parameter int unsigned AW    = 12,
  parameter int unsigned OW    = 6,
  parameter int unsigned SHIFT = 6
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic                    RELU_EN,
  input  logic [TAPS*WW-1:0]      W_IN,
  input  logic [NCH-1:0]          A_IN,
  input  logic                    A_VALID,
  output logic                    A_READY,
  output logic signed [OW-1:0]    CMP,
  output logic [$clog2(NCH)-1:0]  MAX_IDX,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    BUSY
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  // Reduce counter must reach NCH: one extra slot for the lane-value pipeline stage.
  localparam int unsigned RW = $clog2(NCH + 1);

  // Lane clamp bounds expressed at accumulator width (assumes OW <= AW).
  localparam logic signed [AW-1:0] LaneMax = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] LaneMin = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StReduce, StOut} state_e;

  state_e               state_q, state_d;
  logic signed [AW-1:0] acc_q [NCH];
  logic signed [AW-1:0] acc_d [NCH];
  logic [TW-1:0]        tap_q, tap_d;
  logic [RW-1:0]        red_q, red_d;
  logic signed [OW-1:0] lane_v_q, lane_v_d;
  logic signed [OW-1:0] best_q, best_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 relu_q, relu_d;
  logic signed [OW-1:0] cmp_q, cmp_d;
  logic [IW-1:0]        max_idx_q, max_idx_d;
  logic                 out_valid_q, out_valid_d;

  logic signed [WW-1:0] w_tap;
  logic [IW-1:0]        fetch_idx;
  logic signed [OW-1:0] cand_best;
  logic [IW-1:0]        cand_idx;

  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [WW-1:0] w);
    logic [AW:0] s;
    s = {a[AW-1], a} + {{(AW+1-WW){w[WW-1]}}, w};
    // Overflow when the two top bits of the widened sum disagree.
    if (s[AW] != s[AW-1]) begin
      sat_add = s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sat_add = s[AW-1:0];
    end
  endfunction

  function automatic logic signed [OW-1:0] lane_val(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] sh;
    sh = a >>> SHIFT;
    if (sh > LaneMax) begin
      sh = LaneMax;
    end else if (sh < LaneMin) begin
      sh = LaneMin;
    end
    lane_val = sh[OW-1:0];
  endfunction

  assign w_tap     = W_IN[tap_q*WW +: WW];
  assign fetch_idx = (red_q < RW'(NCH)) ? IW'(red_q) : '0;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_d       = tap_q;
    red_d       = red_q;
    lane_v_d    = lane_v_q;
    best_d      = best_q;
    idx_d       = idx_q;
    relu_d      = relu_q;
    cmp_d       = cmp_q;
    max_idx_d   = max_idx_q;
    out_valid_d = out_valid_q;
    cand_best   = best_q;
    cand_idx    = idx_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          for (int i = 0; i < NCH; i++) begin
            acc_d[i] = '0;
          end
          tap_d   = '0;
          relu_d  = RELU_EN;
          state_d = StAcc;
        end
      end

      StAcc: begin
        if (A_VALID) begin
          for (int i = 0; i < NCH; i++) begin
            acc_d[i] = A_IN[i] ? sat_add(acc_q[i], w_tap) : acc_q[i];
          end
          if (tap_q == TW'(TAPS - 1)) begin
            red_d   = '0;
            state_d = StReduce;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end

      // Slot r fetches lane r into lane_v_q while comparing lane r-1, so the
      // shift/clamp path and the comparator sit in separate cycles.
      StReduce: begin
        if (red_q != RW'(NCH)) begin
          lane_v_d = lane_val(acc_q[fetch_idx]);
        end
        if (red_q != '0) begin
          if (red_q == RW'(1)) begin
            cand_best = lane_v_q;
            cand_idx  = '0;
          end else if (lane_v_q > best_q) begin
            // Strict compare: ties keep the lower lane.
            cand_best = lane_v_q;
            cand_idx  = IW'(red_q - 1'b1);
          end
          best_d = cand_best;
          idx_d  = cand_idx;
        end
        if (red_q == RW'(NCH)) begin
          cmp_d       = (relu_q && cand_best[OW-1]) ? '0 : cand_best;
          max_idx_d   = cand_idx;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end else begin
          red_d = red_q + 1'b1;
        end
      end

      StOut: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
      end
      tap_q       <= '0;
      red_q       <= '0;
      lane_v_q    <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      relu_q      <= 1'b0;
      cmp_q       <= '0;
      max_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_q       <= tap_d;
      red_q       <= red_d;
      lane_v_q    <= lane_v_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      relu_q      <= relu_d;
      cmp_q       <= cmp_d;
      max_idx_q   <= max_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign A_READY   = (state_q == StAcc);
  assign BUSY      = (state_q != StIdle);
  assign CMP       = cmp_q;
  assign MAX_IDX   = max_idx_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_conv_pool_seq.sv
// Directed self-checking bench for conv_pool_seq: default instance plus two
// re-parameterised instances for the saturation corners.
module tb_conv_pool_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  // Default-parameter instance.
  logic              start, relu_en, a_valid, a_ready, out_valid, out_ready, busy;
  logic [71:0]       w_in;
  logic [8:0]        a_in;
  logic signed [5:0] cmp;
  logic [3:0]        max_idx;

  // AW=10 instance (accumulator saturation).
  logic              s_start, s_av, s_ar, s_ov, s_or, s_busy;
  logic [71:0]       s_w;
  logic [8:0]        s_a;
  logic signed [5:0] s_cmp;
  logic [3:0]        s_idx;

  // SHIFT=0, TAPS=1 instance (output clamp).
  logic              h_start, h_av, h_ar, h_ov, h_or, h_busy;
  logic [7:0]        h_w;
  logic [8:0]        h_a;
  logic signed [5:0] h_cmp;
  logic [3:0]        h_idx;

  int n_checks = 0;
  int n_fail   = 0;

  conv_pool_seq u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(start), .RELU_EN(relu_en), .W_IN(w_in), .A_IN(a_in),
    .A_VALID(a_valid), .A_READY(a_ready), .CMP(cmp), .MAX_IDX(max_idx),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .BUSY(busy)
  );

  conv_pool_seq #(.AW(10)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .START(s_start), .RELU_EN(1'b0), .W_IN(s_w), .A_IN(s_a),
    .A_VALID(s_av), .A_READY(s_ar), .CMP(s_cmp), .MAX_IDX(s_idx),
    .OUT_VALID(s_ov), .OUT_READY(s_or), .BUSY(s_busy)
  );

  conv_pool_seq #(.SHIFT(0), .TAPS(1)) u_shf (
    .CLK(CLK), .RST_N(RST_N), .START(h_start), .RELU_EN(1'b0), .W_IN(h_w), .A_IN(h_a),
    .A_VALID(h_av), .A_READY(h_ar), .CMP(h_cmp), .MAX_IDX(h_idx),
    .OUT_VALID(h_ov), .OUT_READY(h_or), .BUSY(h_busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one operation on u_dut: START sampled at edge 0, then beats every edge
  // (or only on even edges when stall is set). Returns the edge at which OUT_VALID
  // was first seen, or -1 if it never rose within the budget.
  task automatic run_op(input logic [71:0] w, input logic [8:0] a, input logic relu,
                        input bit stall, output int out_edge);
    w_in    = w;
    a_in    = a;
    relu_en = relu;
    start   = 1'b1;
    a_valid = 1'b0;
    tick();
    start    = 1'b0;
    relu_en  = ~relu;  // must have been latched at START
    out_edge = -1;
    for (int n = 1; n <= 60; n++) begin
      a_valid = stall ? (n % 2 == 0) : 1'b1;
      tick();
      if (out_valid) begin
        out_edge = n;
        break;
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #2;
    n_checks++;
    if (cmp !== 6'd0 || max_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_out: got cmp=%0d idx=%0d expected 0/0", cmp, max_idx);
    end
    n_checks++;
    if (out_valid !== 1'b0 || a_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got ov=%b ar=%b busy=%b expected 0/0/0",
               out_valid, a_ready, busy);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int e;
    run_op({9{8'h10}}, 9'h1FF, 1'b0, 1'b0, e);
    n_checks++;
    if (e != 19) begin
      n_fail++;
      $display("FAIL basic_latency: got edge %0d expected 19", e);
    end
    n_checks++;
    if (cmp !== 6'sd2 || max_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_result: got cmp=%0d idx=%0d expected 2/0", cmp, max_idx);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    handshake();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || cmp !== 6'sd2) begin
      n_fail++;
      $display("FAIL basic_after_hs: got ov=%b busy=%b cmp=%0d expected 0/0/2",
               out_valid, busy, cmp);
    end
  endtask

  task automatic test_negative_relu();
    int e;
    run_op({9{8'hC0}}, 9'h1FF, 1'b0, 1'b0, e);
    n_checks++;
    if (e != 19 || cmp !== 6'h37 || max_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL neg_norelu: got edge=%0d cmp=%h idx=%0d expected 19/37/0",
               e, cmp, max_idx);
    end
    handshake();
    run_op({9{8'hC0}}, 9'h1FF, 1'b1, 1'b0, e);
    n_checks++;
    if (e != 19 || cmp !== 6'h00 || max_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL neg_relu: got edge=%0d cmp=%h idx=%0d expected 19/00/0", e, cmp, max_idx);
    end
    handshake();
  endtask

  task automatic test_single_lane();
    int e;
    run_op({9{8'h40}}, 9'h008, 1'b0, 1'b0, e);
    n_checks++;
    if (cmp !== 6'sd9 || max_idx !== 4'd3) begin
      n_fail++;
      $display("FAIL lane3: got cmp=%0d idx=%0d expected 9/3", cmp, max_idx);
    end
    handshake();
  endtask

  task automatic test_saturation();
    int e;
    s_w     = {9{8'h7F}};
    s_a     = 9'h1FF;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_av    = 1'b1;
    e = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (s_ov) begin
        e = n;
        break;
      end
    end
    s_av = 1'b0;
    n_checks++;
    if (e != 19 || s_cmp !== 6'sd7 || s_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_acc: got edge=%0d cmp=%0d idx=%0d expected 19/7/0", e, s_cmp, s_idx);
    end
    s_or = 1'b1;
    tick();
    s_or = 1'b0;

    h_w     = 8'd100;
    h_a     = 9'h1FF;
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    h_av    = 1'b1;
    e = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (h_ov) begin
        e = n;
        break;
      end
    end
    h_av = 1'b0;
    n_checks++;
    if (e != 11 || h_cmp !== 6'sd31 || h_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_out: got edge=%0d cmp=%0d idx=%0d expected 11/31/0", e, h_cmp, h_idx);
    end
    h_or = 1'b1;
    tick();
    h_or = 1'b0;
  endtask

  task automatic test_stall();
    int e;
    run_op({9{8'h10}}, 9'h1FF, 1'b0, 1'b1, e);
    n_checks++;
    if (e != 28 || cmp !== 6'sd2 || max_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL stall: got edge=%0d cmp=%0d idx=%0d expected 28/2/0", e, cmp, max_idx);
    end
    handshake();
  endtask

  task automatic test_out_hold();
    int e;
    run_op({9{8'h10}}, 9'h1FF, 1'b0, 1'b0, e);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (cmp !== 6'sd2 || out_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL out_hold[%0d]: got cmp=%0d ov=%b busy=%b expected 2/1/1",
                 k, cmp, out_valid, busy);
      end
    end
    // START coincident with the handshake edge must be ignored.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || cmp !== 6'sd2) begin
      n_fail++;
      $display("FAIL out_release: got ov=%b busy=%b cmp=%0d expected 0/0/2",
               out_valid, busy, cmp);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got busy=%b ar=%b expected 0/0", busy, a_ready);
    end
  endtask

  task automatic test_reset_mid_acc();
    int e;
    w_in    = {9{8'h40}};
    a_in    = 9'h008;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    n_checks++;
    if (a_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_acc_state: got ar=%b busy=%b expected 1/1", a_ready, busy);
    end
    RST_N   = 1'b0;
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (cmp !== 6'd0 || max_idx !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got cmp=%0d idx=%0d ov=%b busy=%b ar=%b expected all 0",
               cmp, max_idx, out_valid, busy, a_ready);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    run_op({9{8'h10}}, 9'h1FF, 1'b0, 1'b0, e);
    n_checks++;
    if (e != 19 || cmp !== 6'sd2 || max_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL rerun: got edge=%0d cmp=%0d idx=%0d expected 19/2/0", e, cmp, max_idx);
    end
    handshake();
  endtask

  initial begin
    RST_N     = 1'b0;
    start     = 1'b0;
    relu_en   = 1'b0;
    w_in      = '0;
    a_in      = '0;
    a_valid   = 1'b0;
    out_ready = 1'b0;
    s_start   = 1'b0;
    s_w       = '0;
    s_a       = '0;
    s_av      = 1'b0;
    s_or      = 1'b0;
    h_start   = 1'b0;
    h_w       = '0;
    h_a       = '0;
    h_av      = 1'b0;
    h_or      = 1'b0;

    test_reset();
    test_basic();
    test_negative_relu();
    test_single_lane();
    test_saturation();
    test_stall();
    test_out_hold();
    test_reset_mid_acc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
